// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache between the fetch stage and IF/ID.
// On a miss, a whole line is refilled from instruction memory and the missed word is delivered.
module icache_dm #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc_i,
    input  logic        if_valid_req_i,
    input  logic        if_jump_stop_Icache_i,
    output logic [31:0] ic_inst_o,
    output logic [31:0] ic_pc_o,
    output logic        ic_inst_valid_o,
    output logic        ic_stall_flag_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, MREQ, REFILL} state_t;

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];
    logic [NUM_LINES-1:0] valid_bits;

    state_t              state;
    logic [31:0]         miss_pc;
    logic [WSEL_W-1:0]   cnt;
    logic                drop;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;
    logic              hit;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic [WSEL_W-1:0] miss_word;
    logic              beat;
    logic              last_beat;
    logic              unused_pc_bits;

    assign req_idx   = if_pc_i[OFF_W +: IDX_W];
    assign req_tag   = if_pc_i[31 -: TAG_W];
    assign req_word  = if_pc_i[2 +: WSEL_W];
    assign hit       = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);

    assign miss_idx  = miss_pc[OFF_W +: IDX_W];
    assign miss_tag  = miss_pc[31 -: TAG_W];
    assign miss_word = miss_pc[2 +: WSEL_W];

    assign beat      = (state == REFILL) && mem_rvalid_i;
    assign last_beat = beat && (cnt == LAST_WORD);

    // Byte offset within a word is meaningless for a word-aligned fetch.
    assign unused_pc_bits = ^if_pc_i[1:0];

    // NOTE: tag and data arrays carry no reset; the reset valid bits already mask stale contents.
    always_ff @(posedge clk) begin
        if (beat) begin
            data_mem[miss_idx][cnt] <= mem_rdata_i;
        end
        if (last_beat) begin
            tag_mem[miss_idx] <= miss_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            miss_pc         <= '0;
            cnt             <= '0;
            drop            <= 1'b0;
            valid_bits      <= '0;
            ic_inst_o       <= '0;
            ic_pc_o         <= '0;
            ic_inst_valid_o <= 1'b0;
            ic_stall_flag_o <= 1'b0;
            mem_req_o       <= 1'b0;
            mem_addr_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ic_inst_valid_o <= 1'b0;
                    drop            <= 1'b0;
                    if (if_valid_req_i) begin
                        if (hit) begin
                            ic_inst_valid_o <= 1'b1;
                            ic_inst_o       <= data_mem[req_idx][req_word];
                            ic_pc_o         <= if_pc_i;
                        end else begin
                            ic_stall_flag_o <= 1'b1;
                            mem_req_o       <= 1'b1;
                            mem_addr_o      <= {if_pc_i[31:OFF_W], {OFF_W{1'b0}}};
                            miss_pc         <= if_pc_i;
                            state           <= MREQ;
                        end
                    end
                end
                MREQ: begin
                    if (if_jump_stop_Icache_i) drop <= 1'b1;
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (if_jump_stop_Icache_i) drop <= 1'b1;
                    if (beat) begin
                        if (last_beat) begin
                            cnt                  <= '0;
                            drop                 <= 1'b0;
                            valid_bits[miss_idx] <= 1'b1;
                            ic_stall_flag_o      <= 1'b0;
                            ic_pc_o              <= miss_pc;
                            // A redirect arriving with the last beat also kills the delivery.
                            ic_inst_valid_o      <= !(drop || if_jump_stop_Icache_i);
                            ic_inst_o            <= (miss_word == LAST_WORD) ? mem_rdata_i
                                                                           : data_mem[miss_idx][miss_word];
                            state                <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: deliveries are checked by a scoreboard monitor,
// memory handshake and stall timing are checked inline by the stimulus thread.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc_i;
    logic        if_valid_req_i;
    logic        if_jump_stop_Icache_i;
    logic [31:0] ic_inst_o;
    logic [31:0] ic_pc_o;
    logic        ic_inst_valid_o;
    logic        ic_stall_flag_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    icache_dm dut (
        .clk                   (clk),
        .rst                   (rst),
        .if_pc_i               (if_pc_i),
        .if_valid_req_i        (if_valid_req_i),
        .if_jump_stop_Icache_i (if_jump_stop_Icache_i),
        .ic_inst_o             (ic_inst_o),
        .ic_pc_o               (ic_pc_o),
        .ic_inst_valid_o       (ic_inst_valid_o),
        .ic_stall_flag_o       (ic_stall_flag_o),
        .mem_req_o             (mem_req_o),
        .mem_addr_o            (mem_addr_o),
        .mem_ready_i           (mem_ready_i),
        .mem_rvalid_i          (mem_rvalid_i),
        .mem_rdata_i           (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle fetch request.
    task automatic req(input logic [31:0] pc);
        if_pc_i        = pc;
        if_valid_req_i = 1'b1;
        tick();
        if_valid_req_i = 1'b0;
    endtask

    // Memory responder for one line refill; jump_beat < 0 means no redirect pulse.
    task automatic serve(input logic [31:0] addr,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int rdy_dly, input int gap, input int jump_beat);
        logic [31:0] w [4];
        int t;
        w = '{w0, w1, w2, w3};
        t = 0;
        while (!mem_req_o && t < 20) begin
            tick();
            t++;
        end
        check("mem_req_seen", 32'(mem_req_o), 32'd1);
        check("mem_addr", mem_addr_o, addr);
        check("stall_in_mreq", 32'(ic_stall_flag_o), 32'd1);
        repeat (rdy_dly) begin
            tick();
            check("mem_req_hold", 32'(mem_req_o), 32'd1);
            check("mem_addr_hold", mem_addr_o, addr);
        end
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check("mem_req_release", 32'(mem_req_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i          = 1'b1;
            mem_rdata_i           = w[i];
            if_jump_stop_Icache_i = (i == jump_beat);
            tick();
            mem_rvalid_i          = 1'b0;
            mem_rdata_i           = 32'hDEAD_BEEF;
            if_jump_stop_Icache_i = 1'b0;
            if (i < 3) begin
                check("stall_in_refill", 32'(ic_stall_flag_o), 32'd1);
                repeat (gap) tick();
            end
        end
        check("stall_after_refill", 32'(ic_stall_flag_o), 32'd0);
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("valid_stall_exclusive", 32'(ic_inst_valid_o & ic_stall_flag_o), 32'd0);
                if (ic_inst_valid_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_delivery", 32'(ic_inst_valid_o), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("deliver_inst", ic_inst_o, e.inst);
                        check("deliver_pc", ic_pc_o, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                   = 1'b1;
        if_pc_i               = '0;
        if_valid_req_i        = 1'b0;
        if_jump_stop_Icache_i = 1'b0;
        mem_ready_i           = 1'b0;
        mem_rvalid_i          = 1'b0;
        mem_rdata_i           = '0;
        repeat (3) tick();
        check("rst_valid", 32'(ic_inst_valid_o), 32'd0);
        check("rst_stall", 32'(ic_stall_flag_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_inst", ic_inst_o, 32'd0);
        check("rst_pc", ic_pc_o, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss at 0x0.
        sb.push_back('{inst: 32'h11, pc: 32'h0});
        req(32'h0);
        check("cold_stall", 32'(ic_stall_flag_o), 32'd1);
        serve(32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, -1);
        tick();

        // Streaming hits on the same line, one per cycle.
        sb.push_back('{inst: 32'h22, pc: 32'h4});
        sb.push_back('{inst: 32'h33, pc: 32'h8});
        sb.push_back('{inst: 32'h44, pc: 32'hC});
        if_valid_req_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if_pc_i = 32'(i * 4);
            tick();
            check("stream_valid", 32'(ic_inst_valid_o), 32'd1);
            check("stream_stall", 32'(ic_stall_flag_o), 32'd0);
        end
        if_valid_req_i = 1'b0;
        tick();
        check("idle_valid_low", 32'(ic_inst_valid_o), 32'd0);

        // Conflict: 0x400 evicts line 0, then 0x0 misses again.
        sb.push_back('{inst: 32'hA0, pc: 32'h400});
        req(32'h400);
        check("conflict_stall", 32'(ic_stall_flag_o), 32'd1);
        serve(32'h400, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, -1);
        tick();
        sb.push_back('{inst: 32'h11, pc: 32'h0});
        req(32'h0);
        check("evicted_stall", 32'(ic_stall_flag_o), 32'd1);
        serve(32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, -1);
        tick();

        // Jump during refill: delivery dropped, line still installed.
        req(32'h100);
        serve(32'h100, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 0, 1);
        repeat (2) tick();
        sb.push_back('{inst: 32'hB1, pc: 32'h104});
        req(32'h104);
        check("post_jump_hit_stall", 32'(ic_stall_flag_o), 32'd0);
        check("post_jump_hit_valid", 32'(ic_inst_valid_o), 32'd1);
        tick();

        // Slow memory, miss on the last word of the line, then hits check word order.
        sb.push_back('{inst: 32'hC3, pc: 32'h20C});
        req(32'h20C);
        serve(32'h200, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 3, 1, -1);
        tick();
        sb.push_back('{inst: 32'hC0, pc: 32'h200});
        sb.push_back('{inst: 32'hC2, pc: 32'h208});
        req(32'h200);
        req(32'h208);
        tick();

        // Reset mid-refill after two beats.
        req(32'h300);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hE0 + 32'(i);
            tick();
        end
        mem_rvalid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(ic_stall_flag_o), 32'd0);
        check("midrst_mem_req", 32'(mem_req_o), 32'd0);
        check("midrst_valid", 32'(ic_inst_valid_o), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 2; i < 4; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hE0 + 32'(i);
            tick();
        end
        mem_rvalid_i = 1'b0;
        check("late_beats_ignored_stall", 32'(ic_stall_flag_o), 32'd0);
        check("late_beats_ignored_valid", 32'(ic_inst_valid_o), 32'd0);
        sb.push_back('{inst: 32'hF0, pc: 32'h300});
        req(32'h300);
        check("rereq_miss_stall", 32'(ic_stall_flag_o), 32'd1);
        serve(32'h300, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 0, 0, -1);
        repeat (3) tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
